// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared types and constants for the decoder scan sequencer.
package decoder_pkg;

    typedef enum logic {
        IDLE,
        SCAN
    } scan_state_t;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    // First unmasked channel of a sweep: lowest index ascending, highest descending.
    function automatic logic [SEL_W-1:0] first_sel(input logic [N_CH-1:0] skip,
                                                   input logic            dir);
        logic [SEL_W-1:0] f;
        f = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (dir) begin
                if (!skip[i]) f = SEL_W'(i);
            end else begin
                if (!skip[N_CH-1-i]) f = SEL_W'(N_CH-1-i);
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// Control/status bundle between the sweep requester and the scan sequencer.
interface decoder_scan_ctrl_if;
    import decoder_pkg::*;

    logic              start;
    logic              stop;
    logic              cont;
    logic              dir;
    logic [N_CH-1:0]   skip;
    logic              E;
    logic [SEL_W-1:0]  In;
    logic              busy;
    logic              done;
    logic              wrap;

    modport master (
        output start, stop, cont, dir, skip,
        input  E, In, busy, done, wrap
    );

    modport slave (
        input  start, stop, cont, dir, skip,
        output E, In, busy, done, wrap
    );

endinterface

// File: rtl/scan_next_sel.sv
// Combinational channel search over the latched skip mask, without wrapping.
module scan_next_sel
    import decoder_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic [N_CH-1:0]  skip,
    input  logic             dir,
    output logic [SEL_W-1:0] nxt,
    output logic             last,
    output logic [SEL_W-1:0] first
);

    // Nearest unmasked channel ahead of sel; the loop order makes the nearest one win.
    always_comb begin
        nxt  = sel;
        last = 1'b1;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (dir) begin
                if (!skip[i] && (SEL_W'(i) < sel)) begin
                    nxt  = SEL_W'(i);
                    last = 1'b0;
                end
            end else begin
                if (!skip[N_CH-1-i] && (SEL_W'(N_CH-1-i) > sel)) begin
                    nxt  = SEL_W'(N_CH-1-i);
                    last = 1'b0;
                end
            end
        end
    end

    assign first = first_sel(skip, dir);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Sweeps the 3-to-8 decoder select across unmasked channels with a fixed dwell.
module decoder_scan_ctrl
    import decoder_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic                clka,
    input  logic                rst,
    decoder_scan_ctrl_if.slave  bus
);

    localparam int unsigned     CNT_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

    scan_state_t       state,  state_n;
    logic [SEL_W-1:0]  sel,    sel_n;
    logic [CNT_W-1:0]  cnt,    cnt_n;
    logic              cont_q, cont_n;
    logic              dir_q,  dir_n;
    logic [N_CH-1:0]   skip_q, skip_n;
    logic              done_q, done_n;
    logic              wrap_q, wrap_n;

    logic [SEL_W-1:0]  nxt_sel;
    logic              last_sel;
    logic [SEL_W-1:0]  first_lat;

    scan_next_sel u_next (
        .sel   (sel),
        .skip  (skip_q),
        .dir   (dir_q),
        .nxt   (nxt_sel),
        .last  (last_sel),
        .first (first_lat)
    );

    // State, select, dwell counter, latched sweep settings and pulse registers.
    always_ff @(posedge clka) begin
        if (rst) begin
            state  <= IDLE;
            sel    <= '0;
            cnt    <= '0;
            cont_q <= 1'b0;
            dir_q  <= 1'b0;
            skip_q <= '0;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            state  <= state_n;
            sel    <= sel_n;
            cnt    <= cnt_n;
            cont_q <= cont_n;
            dir_q  <= dir_n;
            skip_q <= skip_n;
            done_q <= done_n;
            wrap_q <= wrap_n;
        end
    end

    // Next-state logic: start/latch in IDLE, dwell/advance/wrap/abort in SCAN.
    always_comb begin
        state_n = state;
        sel_n   = sel;
        cnt_n   = cnt;
        cont_n  = cont_q;
        dir_n   = dir_q;
        skip_n  = skip_q;
        done_n  = 1'b0;
        wrap_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    if (&bus.skip) begin
                        done_n = 1'b1;
                    end else begin
                        // First channel comes from the incoming mask, not the latched one.
                        cont_n  = bus.cont;
                        dir_n   = bus.dir;
                        skip_n  = bus.skip;
                        sel_n   = first_sel(bus.skip, bus.dir);
                        cnt_n   = '0;
                        state_n = SCAN;
                    end
                end
            end
            SCAN: begin
                if (bus.stop) begin
                    state_n = IDLE;
                end else if (cnt == CNT_MAX) begin
                    cnt_n = '0;
                    if (!last_sel) begin
                        sel_n = nxt_sel;
                    end else if (cont_q) begin
                        sel_n  = first_lat;
                        wrap_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.E    = (state == SCAN);
    assign bus.busy = (state == SCAN);
    assign bus.In   = sel;
    assign bus.done = done_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Randomized and directed bench for decoder_scan_ctrl against a queue-based sweep model.
module tb_decoder_scan_ctrl;
    import decoder_pkg::*;

    localparam int unsigned DWELL = 4;

    logic clka = 1'b0;
    logic rst  = 1'b1;

    decoder_scan_ctrl_if bus ();

    decoder_scan_ctrl #(.DWELL(DWELL)) dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clka = ~clka;

    int checks   = 0;
    int failures = 0;
    int e_cycles = 0;

    // Reference model: a pass is a list of channel values, one entry per dwell cycle.
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    bit         m_wrap = 1'b0;
    bit         m_cont = 1'b0;
    logic [2:0] m_in   = '0;
    int         pass[$];
    int         sched[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void build_pass(input logic [7:0] sk, input logic d);
        pass.delete();
        for (int c = 0; c < 8; c++) begin
            int ch;
            ch = d ? 7 - c : c;
            if (!sk[ch])
                for (int k = 0; k < int'(DWELL); k++) pass.push_back(ch);
        end
    endfunction

    function automatic void model_step();
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_wrap = 1'b0; m_cont = 1'b0; m_in = '0;
            sched.delete();
        end else if (!m_busy) begin
            m_done = 1'b0;
            m_wrap = 1'b0;
            if (bus.start && !bus.stop) begin
                build_pass(bus.skip, bus.dir);
                if (pass.size() == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_busy = 1'b1;
                    m_cont = bus.cont;
                    sched  = pass;
                    m_in   = 3'(sched.pop_front());
                end
            end
        end else begin
            m_done = 1'b0;
            m_wrap = 1'b0;
            if (bus.stop) begin
                m_busy = 1'b0;
            end else if (sched.size() > 0) begin
                m_in = 3'(sched.pop_front());
            end else if (m_cont) begin
                sched  = pass;
                m_in   = 3'(sched.pop_front());
                m_wrap = 1'b1;
            end else begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clka);
        model_step();
        #1;
        if (bus.E === 1'b1) e_cycles++;
        check_eq("E",    32'(bus.E),    32'(m_busy));
        check_eq("In",   32'(bus.In),   32'(m_in));
        check_eq("busy", 32'(bus.busy), 32'(m_busy));
        check_eq("done", 32'(bus.done), 32'(m_done));
        check_eq("wrap", 32'(bus.wrap), 32'(m_wrap));
    endtask

    task automatic start_sweep(input logic [7:0] sk, input logic d, input logic c);
        bus.skip  = sk;
        bus.dir   = d;
        bus.cont  = c;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.cont = 1'b0; bus.dir = 1'b0; bus.skip = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Ascending single pass: 32 enabled cycles, then done.
        e_cycles = 0;
        start_sweep(8'h00, 1'b0, 1'b0);
        repeat (36) tick();
        check_eq("asc_enabled_cycles", 32'(e_cycles), 32'd32);

        // Descending with mask: channels 6,4,3,1.
        e_cycles = 0;
        start_sweep(8'b1010_0101, 1'b1, 1'b0);
        repeat (20) tick();
        check_eq("desc_enabled_cycles", 32'(e_cycles), 32'd16);

        // Continuous on a single channel, then abort.
        start_sweep(8'hFE, 1'b0, 1'b1);
        repeat (21) tick();
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        repeat (3) tick();

        // Abort while In=3 on an ascending pass.
        start_sweep(8'h00, 1'b0, 1'b0);
        for (int n = 0; n < 40 && !(m_busy && m_in == 3'd3); n++) tick();
        check_eq("abort_reached_ch3", 32'(m_in), 32'd3);
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        repeat (3) tick();

        // All channels masked: done only, E never rises.
        e_cycles = 0;
        start_sweep(8'hFF, 1'b0, 1'b0);
        repeat (3) tick();
        check_eq("allmask_enabled_cycles", 32'(e_cycles), 32'd0);

        // start and stop together in IDLE.
        bus.stop = 1'b1; start_sweep(8'h00, 1'b0, 1'b0); bus.stop = 1'b0;
        repeat (3) tick();

        // Reset mid-sweep at In=5, then a fresh sweep.
        start_sweep(8'h00, 1'b0, 1'b1);
        for (int n = 0; n < 40 && !(m_busy && m_in == 3'd5); n++) tick();
        check_eq("reset_reached_ch5", 32'(m_in), 32'd5);
        rst = 1'b1; tick(); rst = 1'b0;
        start_sweep(8'h00, 1'b0, 1'b0);
        repeat (36) tick();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 299) == 0);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.stop  = ($urandom_range(0, 49) == 0);
            bus.cont  = 1'($urandom_range(0, 1));
            bus.dir   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       bus.skip = 8'hFF;
                1:       bus.skip = ~(8'h01 << $urandom_range(0, 7));
                2:       bus.skip = 8'h00;
                default: bus.skip = 8'($urandom);
            endcase
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_scan_ctrl.md
# decoder_scan_ctrl

Sequencer directly upstream of the 3-to-8 `decoder`: it drives the decoder's enable `E` and 3-bit select `In` so that the decoder's one-hot `Out` steps through its eight lines. Each selected line is held for a fixed dwell time. A latched skip mask removes lines from the sweep. Sweeps run up or down, as a single pass or continuously, and are clocked from `clka` of `clkgen`.

## Interface
- `DWELL`, default 4: cycles each selected channel stays enabled; legal range 1..255.
- `clka`  in  1: sole clock; everything is updated on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: level-sampled in IDLE; begins a sweep.
- `stop`  in  1: aborts a sweep at the next edge.
- `cont`  in  1: sampled at start; 1 = continuous sweeps, 0 = single pass.
- `dir`  in  1: sampled at start; 0 = ascending 0→7, 1 = descending 7→0.
- `skip`  in  8: sampled at start; bit i = 1 removes channel i from the sweep.
- `E`  out  1: decoder enable; high only while a channel is being dwelt on.
- `In`  out  3: decoder select; valid whenever `E`=1.
- `busy`  out  1: high in SCAN.
- `done`  out  1: one-cycle pulse marking the end of a single pass.
- `wrap`  out  1: one-cycle pulse on the first dwell cycle of every sweep after the first in continuous mode.

## Operation
- States: IDLE, SCAN.
- Reset values: state IDLE; `E`=0, `In`=0, `busy`=0, `done`=0, `wrap`=0; dwell counter 0; latched cont/dir/skip all 0.
- **IDLE, start=1, stop=0, skip≠8'hFF:**
  - Latch cont, dir and skip.
  - Go to SCAN.
  - Load `In` with the first unmasked channel: lowest index if dir=0, highest if dir=1.
  - `E`=1, `busy`=1, dwell counter = 0.
- **IDLE, start=1, skip=8'hFF:** stay in IDLE and pulse `done` for one cycle. `E` stays 0.
- **IDLE, start=1, stop=1:** stop wins; no action.
- **SCAN dwell:** the counter increments every cycle. When it reaches DWELL−1, the next edge advances `In` to the next unmasked channel in the latched direction and clears the counter. Masked channels consume zero cycles.
- **End of pass:** the last unmasked channel in the sweep direction has finished its dwell.
  - cont=0: next edge goes to IDLE with `E`=0, `busy`=0, `done`=1 for one cycle. `In` holds the last channel.
  - cont=1: next edge reloads the first unmasked channel and asserts `wrap`=1 for one cycle. `E` stays 1 with no gap.
- **Single unmasked channel, continuous mode:** `In` stays constant; `wrap` pulses every DWELL cycles.
- **stop=1 in SCAN:** next edge goes to IDLE, `E`=0, `busy`=0. No `done` or `wrap` pulse. Stop takes priority over advance and wrap in the same cycle.
- **Inputs while busy:** `start`, `cont`, `dir` and `skip` are ignored in SCAN. New values take effect only at the next start.
- **rst mid-sweep:** all outputs return to their reset values at that edge. Any pending `done` or `wrap` is suppressed.

## Timing
- Start-to-enable latency: 1 cycle. `start` is sampled high at edge k; `E`=1 with `In`=first channel is visible after edge k.
- Each unmasked channel is held for exactly DWELL consecutive cycles.
- One full pass with u unmasked channels takes u·DWELL cycles.
- `done` is asserted in the cycle right after the last dwell cycle, in the same cycle `E` falls.
- A new `start` is accepted on the edge at which `done` is high, giving a 1-cycle gap between sweeps.
- `E` never glitches between channels: `In` and the dwell counter change on the same edge.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Shared package `decoder_pkg`, holding:
  - state enum `scan_state_t` {IDLE, SCAN}
  - `N_CH`=8
  - `SEL_W`=3
- Sub-module `scan_next_sel` (combinational), taking current select, latched skip and dir. It returns:
  - `nxt`: next unmasked channel, searched without wrapping
  - `last`: 1 when no unmasked channel remains ahead
  - `first`: first unmasked channel for the latched direction
- Dwell counter width is $clog2(DWELL) with a minimum of 1 bit. DWELL=1 advances every cycle.

## Test plan
- **Ascending single pass:** DWELL=4, skip=0, dir=0, cont=0, start pulse. Required: `In` = 0,1,…,7, each held 4 cycles with `E`=1 (32 cycles). `done` pulses on cycle 33 with `E`=0, and `Out` of the attached decoder walks 8'h01→8'h80.
- **Descending with mask:** skip=8'b1010_0101, dir=1, cont=0. Required: `In` = 6,4,3,1, each held 4 cycles, then `done`.
- **Continuous wrap:** skip=8'hFE, cont=1. Required: `In` stays 0 and `E` stays 1 continuously; `wrap` pulses every 4 cycles starting at cycle 5.
- **Abort:** stop asserted while `In`=3 in an ascending pass. Required: next cycle `E`=0, `busy`=0, with no `done` or `wrap`.
- **Corner starts:**
  - skip=8'hFF: `done` pulses one cycle after start and `E` never rises.
  - start=stop=1 in IDLE: stays idle.
- **Reset mid-sweep:** rst pulsed with `In`=5, then start asserted. Required: all outputs 0 on the rst edge; a fresh sweep then begins from channel 0 with full dwell.
